adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer_if.sv | 33 +++
 rtl/adc_scan_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_sequencer_if.sv
// Purpose : groups the sequencer's control, ADC, serializer and mux signals into one bundle.
// Latency : none; wires only.
// Backpressure: tx_busy stalls word loads; adc_rdy completes a conversion.
// Ports   : slave = sequencer side, master = environment side (config, ADC, serializer, mux).
interface adc_scan_sequencer_if;
  logic        sec;
  logic [6:0]  num_ch;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        adc_start;
  logic        adc_rdy;
  logic [15:0] adc_sample;
  logic        tx_busy;
  logic        tx_start;
  logic [15:0] tx_data;
  logic [3:0]  ENA;
  logic [3:0]  ADDR;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;
  logic [5:0]  ch_idx;

  modport slave (
    input  sec, num_ch, cfg_we, cfg_addr, cfg_data, adc_rdy, adc_sample, tx_busy,
    output adc_start, tx_start, tx_data, ENA, ADDR, frame_done, overrun, timeout_err, ch_idx
  );

  modport master (
    output sec, num_ch, cfg_we, cfg_addr, cfg_data, adc_rdy, adc_sample, tx_busy,
    input  adc_start, tx_start, tx_data, ENA, ADDR, frame_done, overrun, timeout_err, ch_idx
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Purpose : per-frame analog mux scan; sends a sync word then one ADC sample per table channel.
// Latency : sec -> sync-word tx_start in 2 cycles when the serializer is idle; all outputs registered.
// Backpressure: tx_busy holds the SYNC/SEND states; a missing adc_rdy is cut off after TIMEOUT_CLKS.
// Ports   : clock/reset plain; bus.slave carries sec/num_ch, table write port (cfg_*),
//           ADC handshake (adc_start/adc_rdy/adc_sample), serializer (tx_busy/tx_start/tx_data),
//           mux drive (ENA/ADDR) and status (frame_done, overrun, timeout_err, ch_idx).
module adc_scan_sequencer #(
  parameter int          SETTLE_CLKS  = 1220,
  parameter int          GND_CLKS     = 72,
  parameter int          TIMEOUT_CLKS = 4096,
  parameter logic [15:0] SYNC_WORD    = 16'hFF7F
) (
  input logic              clock,
  input logic              reset,
  adc_scan_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SETTLE,
    CONVERT,
    SEND,
    DISCHARGE
  } state_t;

  // One shared counter serves settle, conversion timeout and discharge, so it
  // is sized for the longest of the three.
  localparam int MAX_AB   = (SETTLE_CLKS > GND_CLKS) ? SETTLE_CLKS : GND_CLKS;
  localparam int MAX_CLKS = (MAX_AB > TIMEOUT_CLKS) ? MAX_AB : TIMEOUT_CLKS;
  localparam int CNT_W    = $clog2(MAX_CLKS + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CLKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GND_LAST     = CNT_W'(GND_CLKS - 1);

  // Parking position of the mux between samples.
  localparam logic [3:0] GND_ENA  = 4'h1;
  localparam logic [3:0] GND_ADDR = 4'hF;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       ch_idx_q, ch_idx_nxt;
  logic [6:0]       eff_ch_q, eff_ch_nxt;
  logic [3:0]       ena_q, ena_nxt;
  logic [3:0]       addr_q, addr_nxt;
  logic [15:0]      word_q, word_nxt;
  logic [15:0]      tx_data_q, tx_data_nxt;
  logic             tx_start_q, tx_start_nxt;
  logic             adc_start_q, adc_start_nxt;
  logic             frame_done_q, frame_done_nxt;
  logic             overrun_q, overrun_nxt;
  logic             timeout_q, timeout_nxt;
  logic             sec_d;

  logic [7:0]       tbl [64];

  logic [5:0]       next_idx;
  logic [6:0]       num_ch_eff;
  logic [6:0]       last_idx;
  logic             at_last;

  // Channel table: writes land any cycle; the mux only sees them at the next fetch
  // because ENA/ADDR are copied into their own registers at fetch time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        tbl[i] <= 8'h00;
      end
    end else if (bus.cfg_we) begin
      tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign next_idx = ch_idx_q + 6'd1;

  // Clamp to the 64-entry table. A zero seen while leaving SYNC (num_ch dropped
  // after the frame was accepted) is treated as a single channel so the frame
  // still terminates.
  always_comb begin
    num_ch_eff = bus.num_ch;
    if (bus.num_ch > 7'd64) begin
      num_ch_eff = 7'd64;
    end else if (bus.num_ch == 7'd0) begin
      num_ch_eff = 7'd1;
    end
  end

  assign last_idx = eff_ch_q - 7'd1;
  assign at_last  = ({1'b0, ch_idx_q} == last_idx);

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ch_idx_q     <= 6'd0;
      eff_ch_q     <= 7'd1;
      ena_q        <= GND_ENA;
      addr_q       <= GND_ADDR;
      word_q       <= 16'h0000;
      tx_data_q    <= 16'h0000;
      tx_start_q   <= 1'b0;
      adc_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      sec_d        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ch_idx_q     <= ch_idx_nxt;
      eff_ch_q     <= eff_ch_nxt;
      ena_q        <= ena_nxt;
      addr_q       <= addr_nxt;
      word_q       <= word_nxt;
      tx_data_q    <= tx_data_nxt;
      tx_start_q   <= tx_start_nxt;
      adc_start_q  <= adc_start_nxt;
      frame_done_q <= frame_done_nxt;
      overrun_q    <= overrun_nxt;
      timeout_q    <= timeout_nxt;
      sec_d        <= bus.sec;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ch_idx_nxt     = ch_idx_q;
    eff_ch_nxt     = eff_ch_q;
    ena_nxt        = ena_q;
    addr_nxt       = addr_q;
    word_nxt       = word_q;
    tx_data_nxt    = tx_data_q;
    tx_start_nxt   = 1'b0;
    adc_start_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    timeout_nxt    = timeout_q;
    // Rising-edge qualified so a stretched sec still gives a single pulse.
    overrun_nxt    = bus.sec && !sec_d && (state != IDLE);

    case (state)
      IDLE: begin
        ena_nxt  = GND_ENA;
        addr_nxt = GND_ADDR;
        cnt_nxt  = '0;
        if (bus.sec && (bus.num_ch != 7'd0)) begin
          state_nxt = SYNC;
        end
      end

      SYNC: begin
        if (!bus.tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = SYNC_WORD;
          ch_idx_nxt   = 6'd0;
          eff_ch_nxt   = num_ch_eff;
          ena_nxt      = tbl[0][3:0];
          addr_nxt     = tbl[0][7:4];
          cnt_nxt      = '0;
          state_nxt    = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          adc_start_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = CONVERT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      CONVERT: begin
        if (bus.adc_rdy) begin
          word_nxt  = bus.adc_sample;
          ena_nxt   = GND_ENA;
          addr_nxt  = GND_ADDR;
          state_nxt = SEND;
        end else if (cnt == TIMEOUT_LAST) begin
          // A dead ADC still yields a zero word so the frame length holds.
          word_nxt    = 16'h0000;
          timeout_nxt = 1'b1;
          ena_nxt     = GND_ENA;
          addr_nxt    = GND_ADDR;
          state_nxt   = SEND;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      SEND: begin
        if (!bus.tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = word_q;
          cnt_nxt      = '0;
          state_nxt    = DISCHARGE;
        end
      end

      DISCHARGE: begin
        if (cnt == GND_LAST) begin
          cnt_nxt = '0;
          if (at_last) begin
            frame_done_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            ch_idx_nxt = next_idx;
            ena_nxt    = tbl[next_idx][3:0];
            addr_nxt   = tbl[next_idx][7:4];
            state_nxt  = SETTLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.adc_start   = adc_start_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.ENA         = ena_q;
  assign bus.ADDR        = addr_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
  assign bus.ch_idx      = ch_idx_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  adc_scan_sequencer_if bus_if ();

  adc_scan_sequencer #(
    .SETTLE_CLKS (4),
    .GND_CLKS    (2),
    .TIMEOUT_CLKS(16),
    .SYNC_WORD   (16'hFF7F)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  mux_q [$];
  logic [15:0] adc_q [$];
  logic [7:0]  tbl_m [64];
  bit          adc_mode = 1'b0;

  int cyc = 0, tx_cnt = 0, frame_cnt = 0, ovr_cnt = 0, adc_cyc = 0, tx_cyc = 0;
  logic prev_tx = 1'b0, prev_adc = 1'b0, prev_fd = 1'b0, prev_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clock) begin
    if (bus_if.tx_start) begin
      check("tx_start_single", 32'(prev_tx), 32'd0);
      tx_cnt++;
      tx_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_extra actual=%0h required=no_word", bus_if.tx_data);
      end else begin
        check("tx_word", 32'(bus_if.tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (bus_if.adc_start) begin
      check("adc_start_single", 32'(prev_adc), 32'd0);
      adc_cyc = cyc;
      if (mux_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mux_extra actual=%0h/%0h required=no_fetch", bus_if.ENA, bus_if.ADDR);
      end else begin
        check("mux_addr_ena", 32'({bus_if.ADDR, bus_if.ENA}), 32'(mux_q.pop_front()));
      end
    end
    if (bus_if.frame_done) begin
      check("frame_done_single", 32'(prev_fd), 32'd0);
      frame_cnt++;
    end
    if (bus_if.overrun) begin
      check("overrun_single", 32'(prev_ovr), 32'd0);
      ovr_cnt++;
    end
    prev_tx  = bus_if.tx_start;
    prev_adc = bus_if.adc_start;
    prev_fd  = bus_if.frame_done;
    prev_ovr = bus_if.overrun;
  end

  // ADC model: answers adc_start with adc_rdy three cycles later.
  initial begin
    logic [15:0] v;
    bus_if.adc_rdy    = 1'b0;
    bus_if.adc_sample = 16'h0000;
    forever begin
      @(negedge clock);
      if (bus_if.adc_start && adc_mode && adc_q.size() > 0) begin
        v = adc_q.pop_front();
        repeat (3) @(posedge clock);
        #1;
        bus_if.adc_rdy    = 1'b1;
        bus_if.adc_sample = v;
        @(posedge clock);
        #1 bus_if.adc_rdy = 1'b0;
      end
    end
  end

  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    @(posedge clock);
    #1;
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = a;
    bus_if.cfg_data = d;
    tbl_m[a]        = d;
    @(posedge clock);
    #1 bus_if.cfg_we = 1'b0;
  endtask

  task automatic pulse_sec();
    @(posedge clock);
    #1 bus_if.sec = 1'b1;
    @(posedge clock);
    #1 bus_if.sec = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int f;
    int n;
    f = frame_cnt;
    n = 0;
    while (frame_cnt == f && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (frame_cnt == f) begin
      total++;
      bad++;
      $display("FAIL frame_wait actual=no_frame_done required=frame_done within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ena"},       32'(bus_if.ENA),         32'h1);
    check({tag, "_addr"},      32'(bus_if.ADDR),        32'hF);
    check({tag, "_tx_data"},   32'(bus_if.tx_data),     32'h0);
    check({tag, "_tx_start"},  32'(bus_if.tx_start),    32'h0);
    check({tag, "_adc_start"}, 32'(bus_if.adc_start),   32'h0);
    check({tag, "_timeout"},   32'(bus_if.timeout_err), 32'h0);
    check({tag, "_ch_idx"},    32'(bus_if.ch_idx),      32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f0, o0, n;
    bus_if.sec      = 1'b0;
    bus_if.num_ch   = 7'd0;
    bus_if.cfg_we   = 1'b0;
    bus_if.cfg_addr = 6'd0;
    bus_if.cfg_data = 8'h00;
    bus_if.tx_busy  = 1'b0;
    for (int i = 0; i < 64; i++) tbl_m[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("rst");
    check("rst_frame_done", 32'(bus_if.frame_done), 32'h0);
    check("rst_overrun",    32'(bus_if.overrun),    32'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic two-channel frame, with sec-to-sync latency
    cfg_write(6'd0, 8'h32);
    cfg_write(6'd1, 8'h54);
    bus_if.num_ch = 7'd2;
    exp_q.push_back(16'hFF7F); exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    mux_q.push_back(8'h32);    mux_q.push_back(8'h54);
    adc_q.push_back(16'h1111); adc_q.push_back(16'h2222);
    adc_mode = 1'b1;
    f0 = frame_cnt;
    pulse_sec();
    @(negedge clock);
    check("sync_lat_cycle1", 32'(bus_if.tx_start), 32'h0);
    @(negedge clock);
    check("sync_lat_cycle2", 32'(bus_if.tx_start), 32'h1);
    wait_frame(300);
    repeat (5) @(posedge clock);
    check("basic_frames", 32'(frame_cnt - f0), 32'd1);
    check("basic_left",   32'(exp_q.size()),   32'd0);
    @(negedge clock);
    check("basic_gnd_ena",  32'(bus_if.ENA),  32'h1);
    check("basic_gnd_addr", 32'(bus_if.ADDR), 32'hF);

    // Serializer busy for 10 cycles after sec
    bus_if.num_ch = 7'd1;
    exp_q.push_back(16'hFF7F); exp_q.push_back(16'h3333);
    mux_q.push_back(8'h32);
    adc_q.push_back(16'h3333);
    t0 = tx_cnt;
    @(posedge clock);
    #1;
    bus_if.sec     = 1'b1;
    bus_if.tx_busy = 1'b1;
    @(posedge clock);
    #1 bus_if.sec = 1'b0;
    repeat (10) @(negedge clock);
    check("busy_no_tx", 32'(tx_cnt - t0), 32'd0);
    @(posedge clock);
    #1 bus_if.tx_busy = 1'b0;
    @(negedge clock);
    check("busy_fall_cycle", 32'(bus_if.tx_start), 32'h0);
    @(negedge clock);
    check("busy_release_tx", 32'(bus_if.tx_start), 32'h1);
    wait_frame(300);
    repeat (3) @(posedge clock);
    check("busy_words", 32'(tx_cnt - t0), 32'd2);

    // Conversion timeout
    check("pre_timeout_flag", 32'(bus_if.timeout_err), 32'h0);
    adc_mode = 1'b0;
    exp_q.push_back(16'hFF7F); exp_q.push_back(16'h0000);
    mux_q.push_back(8'h32);
    f0 = frame_cnt;
    pulse_sec();
    wait_frame(300);
    check("timeout_gap_16_17", 32'((tx_cyc - adc_cyc) >= 16 && (tx_cyc - adc_cyc) <= 17), 32'd1);
    check("timeout_flag", 32'(bus_if.timeout_err), 32'h1);
    check("timeout_frames", 32'(frame_cnt - f0), 32'd1);
    adc_mode = 1'b1;

    // sec during SETTLE
    bus_if.num_ch = 7'd2;
    exp_q.push_back(16'hFF7F); exp_q.push_back(16'h6666); exp_q.push_back(16'h7777);
    mux_q.push_back(8'h32);    mux_q.push_back(8'h54);
    adc_q.push_back(16'h6666); adc_q.push_back(16'h7777);
    o0 = ovr_cnt;
    t0 = tx_cnt;
    pulse_sec();
    @(posedge clock);
    #1 bus_if.sec = 1'b1;
    @(posedge clock);
    #1 bus_if.sec = 1'b0;
    wait_frame(300);
    repeat (5) @(posedge clock);
    check("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("overrun_words",  32'(tx_cnt - t0),  32'd3);

    // num_ch = 0 is ignored
    bus_if.num_ch = 7'd0;
    t0 = tx_cnt;
    f0 = frame_cnt;
    pulse_sec();
    repeat (30) @(posedge clock);
    check("zero_ch_words",  32'(tx_cnt - t0),    32'd0);
    check("zero_ch_frames", 32'(frame_cnt - f0), 32'd0);

    // num_ch = 100 clamps to 64; a mid-frame change is ignored
    cfg_write(6'd63, 8'hA7);
    bus_if.num_ch = 7'd100;
    exp_q.push_back(16'hFF7F);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(16'h4000 + 16'(i));
      adc_q.push_back(16'h4000 + 16'(i));
      mux_q.push_back(tbl_m[i]);
    end
    t0 = tx_cnt;
    pulse_sec();
    repeat (5) @(posedge clock);
    #1 bus_if.num_ch = 7'd3;
    wait_frame(3000);
    repeat (5) @(posedge clock);
    check("clamp_words", 32'(tx_cnt - t0),   32'd65);
    check("clamp_left",  32'(exp_q.size()),  32'd0);

    // Reset during CONVERT
    bus_if.num_ch = 7'd1;
    adc_mode = 1'b0;
    exp_q.push_back(16'hFF7F); exp_q.push_back(16'h0000);
    mux_q.push_back(8'h32);
    pulse_sec();
    n = 0;
    while (!bus_if.adc_start && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus_if.adc_start) begin
      total++;
      bad++;
      $display("FAIL adc_start_wait actual=none required=adc_start within 50 cycles");
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    mux_q.delete();
    @(negedge clock);
    check_reset_vals("midrst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) tbl_m[i] = 8'h00;
    t0 = tx_cnt;
    repeat (20) @(posedge clock);
    check("post_rst_quiet", 32'(tx_cnt - t0), 32'd0);
    cfg_write(6'd0, 8'h76);
    adc_mode = 1'b1;
    adc_q.push_back(16'h5555);
    exp_q.push_back(16'hFF7F); exp_q.push_back(16'h5555);
    mux_q.push_back(8'h76);
    t0 = tx_cnt;
    pulse_sec();
    wait_frame(300);
    repeat (3) @(posedge clock);
    check("post_rst_words",   32'(tx_cnt - t0),         32'd2);
    check("post_rst_left",    32'(exp_q.size()),        32'd0);
    check("post_rst_timeout", 32'(bus_if.timeout_err),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
